fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Parametrised fetch front end: owns the program counter and issues sequential requests to a
//  1-cycle-latency synchronous instruction memory. Buffers returned instructions with their PCs
//  in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
//  Supports branch/jump redirect with full flush and a fetch-enable halt; sits between the
//  instruction memory and the decode stage.
// PARAMETERS
//  XLEN      32   address/PC width in bits
//  ILEN      32   instruction width in bits
//  DEPTH     4    FIFO entries; power of two, >= 2
//  RESET_PC  0    PC loaded on reset; must be 4-byte aligned
// PORTS
//  clk             in   1     clock, all state updates on rising edge
//  rst             in   1     asynchronous, active-low reset
//  fetch_en        in   1     1 = issue new fetches; 0 = halt issue, let FIFO drain
//  redirect_valid  in   1     branch/jump taken this cycle; flush and reload PC
//  redirect_pc     in   XLEN  new PC; bits [1:0] ignored (treated as 0)
//  imem_req        out  1     memory read request this cycle
//  imem_addr       out  XLEN  request address (current PC)
//  imem_rdata      in   ILEN  read data, valid exactly 1 cycle after an accepted imem_req
//  out_valid       out  1     out_instr/out_pc hold a valid entry
//  out_ready       in   1     decode accepts entry when out_valid & out_ready
//  out_instr       out  ILEN  instruction at FIFO head
//  out_pc          out  XLEN  address of out_instr
//  occupancy       out  $clog2(DEPTH)+1  FIFO entries currently held
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, FIFO empty, inflight=0; outputs imem_req=0,
//   out_valid=0, occupancy=0, out_instr/out_pc=0, imem_addr=RESET_PC.
//  State: pc, FIFO (rd/wr ptr + count), inflight flag + inflight_pc register.
//  pop      = out_valid & out_ready & ~redirect_valid.
//  imem_req = fetch_en & ~redirect_valid & (count + inflight - pop < DEPTH); no overflow ever.
//  imem_addr = pc (combinational from register). On imem_req: pc <= pc + 4 (wraps mod 2^XLEN),
//   inflight <= 1, inflight_pc <= pc; else inflight <= 0.
//  Response: in the cycle after a request, push {imem_rdata, inflight_pc} into FIFO.
//  out_valid = (count != 0); output driven from FIFO head, no bypass path.
//  Latency: request in cycle N -> data in FIFO, out_valid=1 in cycle N+2.
//  Throughput: 1 instruction/cycle sustained when out_ready=1 and fetch_en=1.
//  Simultaneous push+pop: count unchanged, both pointers advance; legal at count=DEPTH.
//  Pointers wrap mod DEPTH; count range 0..DEPTH.
//  Redirect (priority over all else): in that cycle imem_req=0, pop suppressed;
//   at the edge pc <= {redirect_pc[XLEN-1:2],2'b00}, FIFO emptied, inflight <= 0, and any
//   response arriving that cycle is discarded. Next cycle: out_valid=0, imem_req may fetch
//   redirect pc. Back-to-back redirects: last one wins.
//  fetch_en=0: no new requests; the inflight response is still pushed; FIFO drains normally.
//  Stall: out_ready=0 holds out_instr/out_pc stable while out_valid=1.
//  Reset asserted mid-operation: immediate return to reset state; in-flight data lost.
// TESTING
//  Reset release, out_ready=1, imem returns addr as data -> imem_addr 0,4,8..; first out_valid
//   2 cycles after first req; out_pc=0,4,8 on consecutive cycles, no bubbles.
//  out_ready=0 for 10 cycles, DEPTH=4 -> occupancy reaches 4, imem_req=0 thereafter,
//   no entry lost/duplicated; raise out_ready -> pcs continue in order, 1/cycle.
//  Redirect to 0x100 while FIFO holds 3 entries and a request is inflight -> next cycle
//   out_valid=0, occupancy=0, imem_addr=0x100; following out_pc=0x100,0x104; old pcs never appear.
//  Full FIFO with out_ready=1 continuously -> push+pop same cycle, occupancy stays at DEPTH-1/DEPTH,
//   sequence gap-free.
//  fetch_en=0 after 2 requests -> exactly 2 entries delivered, then out_valid=0, imem_req=0.
//  rst pulled low mid-stream (async, between edges) -> outputs at reset values immediately;
//   after release, fetch restarts at RESET_PC; redirect_pc=0x103 -> fetches 0x100.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC owner issuing sequential fetches to a 1-cycle imem, buffering {instr, pc} in a FIFO for decode.
// Ports: clk/rst (async active-low); fetch_en halts issue; redirect_valid/redirect_pc flush and reload the PC;
// imem_req/imem_addr/imem_rdata talk to the instruction memory; out_valid/out_ready/out_instr/out_pc hand
// entries to decode; occupancy reports the number of FIFO entries held.
module fetch_queue_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [ILEN-1:0]         imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ILEN-1:0]         out_instr,
    output logic [XLEN-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [ILEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic            pop;
    logic            push;
    logic [AW+1:0]   level;
    assign pop = out_valid & out_ready & ~redirect_valid;
    assign push = inflight & ~redirect_valid;
    // Entries that will be held once the outstanding response lands; a new request must still fit.
    assign level = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
    // Gated by rst so the request drops the moment reset is asserted, not at the next edge.
    assign imem_req = rst & fetch_en & ~redirect_valid & (level < (AW+2)'(DEPTH));
    assign imem_addr = pc;
    assign out_valid = count != '0;
    assign out_instr = instr_q[rd_ptr];
    assign out_pc = pc_q[rd_ptr];
    assign occupancy = count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            inflight_pc <= '0;
            inflight <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr] <= inflight_pc;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: checks fetch_queue_stage against fixed vectors, corner sequences and a queue-based model.
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;
    int total = 0;
    int bad = 0;

    fetch_queue_stage dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Synchronous memory: answers one cycle after a request, garbage otherwise.
    always @(posedge clk) imem_rdata <= imem_req ? mem_data(imem_addr) : $urandom;

    // Reference model: the FIFO is a queue of pcs, the outstanding fetch a flag plus its pc.
    logic [31:0] m_q[$];
    logic [31:0] m_pc = '0;
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;

    task automatic model_reset();
        m_q.delete();
        m_pc = 32'h0;
        m_infl = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop_m, req_m;
        int lvl;
        @(negedge clk);
        fetch_en = en;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        pop_m = (m_q.size() != 0) && rdy && !rv;
        lvl = m_q.size() + int'(m_infl) - int'(pop_m);
        req_m = en && !rv && (lvl < 4);
        chk("m_req", 32'(imem_req), 32'(req_m));
        chk("m_addr", imem_addr, m_pc);
        chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("m_occ", 32'(occupancy), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("m_pc", out_pc, m_q[0]);
            chk("m_instr", out_instr, mem_data(m_q[0]));
        end
        if (rv) begin
            m_q.delete();
            m_pc = rpc & ~32'h3;
            m_infl = 1'b0;
        end else begin
            if (pop_m) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            if (req_m) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
            m_infl = req_m;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic        en, rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1, 0, 0,        1, 1, 32'h000, 0, 32'h000, 0};
        vecs[1]  = '{1, 0, 0,        1, 1, 32'h004, 0, 32'h000, 0};
        vecs[2]  = '{1, 0, 0,        1, 1, 32'h008, 1, 32'h000, 1};
        vecs[3]  = '{1, 0, 0,        1, 1, 32'h00C, 1, 32'h004, 1};
        vecs[4]  = '{1, 1, 32'h103,  1, 0, 32'h010, 1, 32'h008, 1};
        vecs[5]  = '{1, 0, 0,        1, 1, 32'h100, 0, 32'h000, 0};
        vecs[6]  = '{1, 0, 0,        1, 1, 32'h104, 0, 32'h000, 0};
        vecs[7]  = '{1, 0, 0,        1, 1, 32'h108, 1, 32'h100, 1};
        vecs[8]  = '{0, 0, 0,        1, 0, 32'h10C, 1, 32'h104, 1};
        vecs[9]  = '{0, 0, 0,        1, 0, 32'h10C, 1, 32'h108, 1};
        vecs[10] = '{0, 0, 0,        1, 0, 32'h10C, 0, 32'h000, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        rst = 1'b1;

        // Fixed vectors: streaming, redirect to 0x103, fetch halt drain
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_instr", i), out_instr, mem_data(vecs[i].e_pc));
            end
        end

        // Stall 10 cycles: FIFO fills to DEPTH and requests stop, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        chk("stall_occ", 32'(occupancy), 4);
        chk("stall_req", 32'(imem_req), 0);
        chk("stall_head", out_pc, 32'h0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1);

        // Redirect with 3 entries held and one in flight
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("pre_redir_occ", 32'(occupancy), 3);
        step(1, 1, 32'h100, 0);
        step(1, 0, 0, 1);
        chk("redir_valid", 32'(out_valid), 0);
        chk("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

        // Back-to-back redirects, last one wins
        step(1, 1, 32'h200, 1);
        step(1, 1, 32'h303, 1);
        step(1, 0, 0, 1);
        chk("b2b_addr", imem_addr, 32'h300);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

        // Async reset between edges
        step(1, 0, 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_pc", out_pc, 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        step(1, 1, 32'h103, 1);
        step(1, 0, 0, 1);
        chk("arst_redir_addr", imem_addr, 32'h100);

        // Random traffic including PC wrap near the top of the address space
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : 32'($urandom);
            step($urandom_range(7) != 0, $urandom_range(15) == 0, rpc, $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
